// File: rtl/round_robin_arbiter_with_hold_pkg.sv
// rtl/round_robin_arbiter_with_hold_pkg.sv - shared types and constants for the round-robin arbiter
package arbiter_pkg;

   // Width of the tenure counter; saturates at all-ones
   localparam int HOLD_W = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      OWNED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/round_robin_arbiter_with_hold_if.sv
// rtl/round_robin_arbiter_with_hold_if.sv - request/grant bundle between requesters and the arbiter
interface round_robin_arbiter_with_hold_if #(
   parameter int N_REQ = 4
) ();
   localparam int IDX_W = $clog2(N_REQ);

   logic [N_REQ-1:0] requests;
   logic             done;
   logic [N_REQ-1:0] grants;
   logic [IDX_W-1:0] grant_idx;
   logic             busy;

   modport master (
      output requests,
      output done,
      input  grants,
      input  grant_idx,
      input  busy
   );

   modport slave (
      input  requests,
      input  done,
      output grants,
      output grant_idx,
      output busy
   );

endinterface

// File: rtl/round_robin_arbiter_with_hold_picker.sv
// rtl/round_robin_arbiter_with_hold_picker.sv - stateless rotating first-set search starting at ptr
module rr_priority_picker #(
   parameter int N_REQ = 4,
   parameter int IDX_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] requests,
   input  logic [IDX_W-1:0] ptr,
   output logic             found,
   output logic [IDX_W-1:0] idx
);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // Scan from farthest to nearest offset so the candidate closest to ptr wins
   always_comb begin
      found = 1'b0;
      idx   = '0;
      sum   = '0;
      cand  = '0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (IDX_W + 1)'(k);
         if (sum >= (IDX_W + 1)'(N_REQ)) begin
            sum = sum - (IDX_W + 1)'(N_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (requests[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/round_robin_arbiter_with_hold.sv
// rtl/round_robin_arbiter_with_hold.sv - round-robin arbiter with per-tenure hold limit
module round_robin_arbiter_with_hold
   import arbiter_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   round_robin_arbiter_with_hold_if.slave bus
);

   localparam int IDX_W = $clog2(N_REQ);
   localparam logic [HOLD_W-1:0] MAX_HOLD_C = HOLD_W'(MAX_HOLD);

   arb_state_e        state_q, state_d;
   logic [N_REQ-1:0]  grants_q, grants_d;
   logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
   logic              busy_q, busy_d;
   logic [IDX_W-1:0]  ptr_q, ptr_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

   logic [IDX_W-1:0]  ptr_inc;
   logic [IDX_W-1:0]  pick_ptr;
   logic              pick_found;
   logic [IDX_W-1:0]  pick_idx;
   logic              release_c;

   // Pointer one past the owner; while OWNED the next pick already searches from there
   always_comb begin
      ptr_inc  = (grant_idx_q == IDX_W'(N_REQ - 1)) ? '0 : grant_idx_q + 1'b1;
      pick_ptr = (state_q == OWNED) ? ptr_inc : ptr_q;
   end

   rr_priority_picker #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_picker (
      .requests (bus.requests),
      .ptr      (pick_ptr),
      .found    (pick_found),
      .idx      (pick_idx)
   );

   // Next-state: grant from IDLE, hold or hand over back-to-back from OWNED
   always_comb begin
      state_d     = state_q;
      grants_d    = grants_q;
      grant_idx_d = grant_idx_q;
      busy_d      = busy_q;
      ptr_d       = ptr_q;
      hold_cnt_d  = hold_cnt_q;
      release_c   = 1'b0;

      case (state_q)
         IDLE: begin
            if (pick_found) begin
               state_d            = OWNED;
               grants_d           = '0;
               grants_d[pick_idx] = 1'b1;
               grant_idx_d        = pick_idx;
               busy_d             = 1'b1;
               hold_cnt_d         = HOLD_W'(1);
            end
         end
         OWNED: begin
            // Any combination of release causes collapses into one pointer advance
            release_c = !bus.requests[grant_idx_q] || bus.done || (hold_cnt_q == MAX_HOLD_C);
            if (release_c) begin
               ptr_d = ptr_inc;
               if (pick_found) begin
                  grants_d           = '0;
                  grants_d[pick_idx] = 1'b1;
                  grant_idx_d        = pick_idx;
                  busy_d             = 1'b1;
                  hold_cnt_d         = HOLD_W'(1);
               end else begin
                  state_d     = IDLE;
                  grants_d    = '0;
                  grant_idx_d = '0;
                  busy_d      = 1'b0;
                  hold_cnt_d  = '0;
               end
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end
         default: begin
            state_d     = IDLE;
            grants_d    = '0;
            grant_idx_d = '0;
            busy_d      = 1'b0;
            hold_cnt_d  = '0;
         end
      endcase
   end

   // All arbiter state; reset overrides every other event
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         grants_q    <= '0;
         grant_idx_q <= '0;
         busy_q      <= 1'b0;
         ptr_q       <= '0;
         hold_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         grants_q    <= grants_d;
         grant_idx_q <= grant_idx_d;
         busy_q      <= busy_d;
         ptr_q       <= ptr_d;
         hold_cnt_q  <= hold_cnt_d;
      end
   end

   assign bus.grants    = grants_q;
   assign bus.grant_idx = grant_idx_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_round_robin_arbiter_with_hold.sv
// tb/tb_round_robin_arbiter_with_hold.sv - scoreboard bench for the round-robin arbiter
module tb_round_robin_arbiter_with_hold;

   typedef struct {
      int          cyc;
      logic [3:0]  grants;
      logic [1:0]  idx;
      int          hold;
      int          ptr;
      string       name;
   } exp_t;

   logic clk  = 1'b0;
   logic rst0 = 1'b1;
   logic rst1 = 1'b1;
   int   cyc  = 0;
   int   checks   = 0;
   int   failures = 0;

   exp_t q0[$];
   exp_t q1[$];
   exp_t m0;
   exp_t m1;

   round_robin_arbiter_with_hold_if #(.N_REQ(4)) bus0 ();
   round_robin_arbiter_with_hold_if #(.N_REQ(4)) bus1 ();

   round_robin_arbiter_with_hold #(.N_REQ(4), .MAX_HOLD(8)) dut0 (
      .clk (clk),
      .rst (rst0),
      .bus (bus0.slave)
   );

   round_robin_arbiter_with_hold #(.N_REQ(4), .MAX_HOLD(1)) dut1 (
      .clk (clk),
      .rst (rst1),
      .bus (bus1.slave)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_entry(input string unit, input exp_t e, input logic [3:0] ag,
                              input logic [1:0] ai, input logic ab, input int ah, input int ap);
      logic ok;
      ok = (ag === e.grants) && (ai === e.idx) && (ab === (|e.grants)) &&
           ((e.hold < 0) || (ah == e.hold)) && ((e.ptr < 0) || (ap == e.ptr));
      checks++;
      if (!ok) begin
         failures++;
         $display("FAIL %s/%s cyc=%0d actual grants=%b idx=%0d busy=%b hold=%0d ptr=%0d required grants=%b idx=%0d busy=%b hold=%0d ptr=%0d",
                  unit, e.name, e.cyc, ag, ai, ab, ah, ap, e.grants, e.idx, |e.grants, e.hold, e.ptr);
      end
   endtask

   // Monitor: compare outputs one cycle after each stimulus edge
   always @(negedge clk) begin
      if (q0.size() > 0) begin
         if (q0[0].cyc == cyc) begin
            m0 = q0.pop_front();
            check_entry("arb8", m0, bus0.grants, bus0.grant_idx, bus0.busy,
                        int'(dut0.hold_cnt_q), int'(dut0.ptr_q));
         end
      end
      if (q1.size() > 0) begin
         if (q1[0].cyc == cyc) begin
            m1 = q1.pop_front();
            check_entry("arb1", m1, bus1.grants, bus1.grant_idx, bus1.busy,
                        int'(dut1.hold_cnt_q), int'(dut1.ptr_q));
         end
      end
   end

   task automatic step0(input logic r, input logic [3:0] req, input logic d,
                        input logic [3:0] g, input logic [1:0] i, input int h, input int p,
                        input string nm);
      exp_t e;
      @(negedge clk);
      rst0          = r;
      bus0.requests = req;
      bus0.done     = d;
      e.cyc = cyc + 1; e.grants = g; e.idx = i; e.hold = h; e.ptr = p; e.name = nm;
      q0.push_back(e);
   endtask

   task automatic step1(input logic r, input logic [3:0] req, input logic d,
                        input logic [3:0] g, input logic [1:0] i, input int h, input int p,
                        input string nm);
      exp_t e;
      @(negedge clk);
      rst1          = r;
      bus1.requests = req;
      bus1.done     = d;
      e.cyc = cyc + 1; e.grants = g; e.idx = i; e.hold = h; e.ptr = p; e.name = nm;
      q1.push_back(e);
   endtask

   initial begin
      int owners[5];
      owners = '{0, 1, 2, 3, 0};
      bus0.requests = '0;
      bus0.done     = 1'b0;
      bus1.requests = 4'b1111;
      bus1.done     = 1'b0;

      step0(1, 4'b0000, 0, 4'b0000, 0, 0, 0, "reset");
      step0(1, 4'b1111, 0, 4'b0000, 0, 0, 0, "reset_over_req");
      step0(0, 4'b1010, 0, 4'b0010, 1, 1, 0, "first_pick");
      step0(0, 4'b1010, 1, 4'b1000, 3, 1, 2, "ptr_after_release");
      step0(0, 4'b0000, 0, 4'b0000, 0, -1, 0, "drop_to_idle");
      step0(0, 4'b0000, 0, 4'b0000, 0, -1, 0, "idle_stays");

      for (int n = 0; n < 5; n++) begin
         for (int k = 0; k < 8; k++) begin
            step0(0, 4'b1111, 0, 4'(1 << owners[n]), 2'(owners[n]), k + 1, owners[n], "full_load");
         end
      end

      step0(0, 4'b1100, 0, 4'b0100, 2, 1, 1, "drop_at_max_hold");
      step0(0, 4'b0011, 0, 4'b0001, 0, 1, 3, "wrap_from_ptr3");
      step0(0, 4'b0000, 0, 4'b0000, 0, -1, 1, "idle_again");
      step0(0, 4'b0010, 0, 4'b0010, 1, 1, 1, "solo_grant");
      step0(0, 4'b0010, 0, 4'b0010, 1, 2, 1, "solo_hold");
      step0(0, 4'b0010, 1, 4'b0010, 1, 1, 2, "done_regrant");
      step0(0, 4'b0010, 0, 4'b0010, 1, 2, 2, "solo_hold2");
      step0(0, 4'b0010, 0, 4'b0010, 1, 3, 2, "solo_hold3");
      step0(0, 4'b0010, 1, 4'b0010, 1, 1, 2, "done_regrant2");
      step0(0, 4'b0110, 0, 4'b0010, 1, 2, 2, "pair_hold");
      step0(0, 4'b0100, 1, 4'b0100, 2, 1, 2, "drop_and_done");
      step0(0, 4'b1000, 0, 4'b1000, 3, 1, 3, "to_owner3");
      step0(0, 4'b1000, 0, 4'b1000, 3, 2, 3, "owner3_hold");
      step0(1, 4'b1000, 0, 4'b0000, 0, 0, 0, "reset_mid_tenure");
      step0(0, 4'b1000, 0, 4'b1000, 3, 1, 0, "grant_after_reset");
      step0(1, 4'b0000, 0, 4'b0000, 0, 0, 0, "reset_again");
      step0(0, 4'b1110, 0, 4'b0010, 1, 1, 0, "lowest_after_reset");
      step0(0, 4'b0110, 1, 4'b0100, 2, 1, 2, "done_handover");
      step0(0, 4'b0000, 0, 4'b0000, 0, -1, 3, "final_idle");

      step1(1, 4'b1111, 0, 4'b0000, 0, 0, 0, "reset");
      step1(0, 4'b1111, 0, 4'b0001, 0, 1, 0, "rr0");
      step1(0, 4'b1111, 0, 4'b0010, 1, 1, 1, "rr1");
      step1(0, 4'b1111, 0, 4'b0100, 2, 1, 2, "rr2");
      step1(0, 4'b1111, 0, 4'b1000, 3, 1, 3, "rr3");
      step1(0, 4'b1111, 0, 4'b0001, 0, 1, 0, "rr0_wrap");
      step1(0, 4'b1111, 0, 4'b0010, 1, 1, 1, "rr1_wrap");

      repeat (3) @(negedge clk);
      #1;
      while (q0.size() > 0) begin
         m0 = q0.pop_front();
         checks++;
         failures++;
         $display("FAIL leftover_arb8/%s cyc=%0d never compared", m0.name, m0.cyc);
      end
      while (q1.size() > 0) begin
         m1 = q1.pop_front();
         checks++;
         failures++;
         $display("FAIL leftover_arb1/%s cyc=%0d never compared", m1.name, m1.cyc);
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/round_robin_arbiter_with_hold.md
ROUND_ROBIN_ARBITER_WITH_HOLD -- requirements
Module: round_robin_arbiter_with_hold

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter MAX_HOLD, default 8: maximum consecutive grant cycles per tenure, legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on posedge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port requests, input, N_REQ bits: bit i high = requester i wants the shared resource.
REQ-006 SHALL have port done, input, 1 bit: current owner finishes its transaction this cycle; ignored in IDLE.
REQ-007 SHALL have port grants, output, N_REQ bits: registered, one-hot or zero; bit i = requester i owns resource.
REQ-008 SHALL have port grant_idx, output, $clog2(N_REQ) bits: registered index of the owner; 0 when grants is zero.
REQ-009 SHALL have port busy, output, 1 bit: high when and only when grants is nonzero.

Function
REQ-010 SHALL implement two states: IDLE (grants zero) and OWNED (exactly one grant bit set).
REQ-011 SHALL keep a priority pointer ptr; the pick is the first i with requests[i]=1, searching ptr, ptr+1, ... modulo N_REQ.
REQ-012 SHALL, in IDLE with requests nonzero in cycle t, assert grant to the pick in cycle t+1, load hold_cnt=1, enter OWNED.
REQ-013 SHALL, in IDLE with requests zero, stay IDLE; grants, grant_idx, busy stay zero.
REQ-014 SHALL, in OWNED with owner g, release when requests[g]=0 OR done=1 OR hold_cnt==MAX_HOLD; the release cycle is the last cycle grants[g] is high.
REQ-015 SHALL, in OWNED without release, keep grants unchanged and increment hold_cnt (saturating, 8 bits).
REQ-016 SHALL, on release of owner g, set ptr=(g+1) mod N_REQ in the same edge that drops the grant.
REQ-017 SHALL, on release, pick from the current requests using the updated ptr; if the pick exists, grant it in the next cycle with hold_cnt=1 (back-to-back, no idle bubble), else go IDLE.
REQ-018 SHALL allow the released owner to be regranted only when no other requester is active (wrap-around of search).
REQ-019 SHALL ignore requests changes on non-owner bits while OWNED; they affect only the next pick.
REQ-020 SHALL, when requests[g]=0 and done=1 coincide, treat it as a single release (no double pointer advance).
REQ-021 SHALL give with MAX_HOLD=1 a one-cycle tenure per grant, i.e. pure per-cycle round robin under full load.
REQ-022 SHALL never assert more than one grant bit in any cycle.

Reset
REQ-023 SHALL, while rst=1 at a posedge, set state IDLE, grants=0, grant_idx=0, busy=0, ptr=0, hold_cnt=0.
REQ-024 SHALL give reset priority over every other event, including mid-tenure; first grant after reset goes to the lowest active index.
REQ-025 SHALL issue its first possible grant in the cycle after the first posedge with rst=0 and requests nonzero, counted from that edge.

Structure
REQ-026 SHALL place the state enum (IDLE, OWNED) and the hold counter width constant in shared package arbiter_pkg.
REQ-027 SHALL implement the rotating pick in one combinational sub-module rr_priority_picker (inputs requests and ptr; outputs found and idx).
REQ-028 SHALL keep all flops in the top module; the sub-module SHALL contain no state.

Verification
REQ-029 SHALL cover the following case: after reset, requests=4'b1010 at t -> grants=4'b0010, grant_idx=1 at t+1; ptr=2 after release.
REQ-030 SHALL cover the following case: requests=4'b1111 held, done=0, MAX_HOLD=8 -> each owner holds exactly 8 cycles, order 0,1,2,3,0, no idle gap.
REQ-031 SHALL cover the following case: owner 2 drops req while requests=4'b0011 -> next cycle grants=4'b0001 (wrap from ptr=3).
REQ-032 SHALL cover the following case: only requester 1 active, done pulses every 3 cycles -> grants=4'b0010 continuously and regranted, hold_cnt restarts at 1.
REQ-033 SHALL cover the following case: rst=1 asserted mid-tenure of owner 3 -> next cycle grants=0, busy=0; with requests=4'b1000 the grant returns one cycle after rst drops.
REQ-034 SHALL cover the following case: requests[g]=0 and done=1 in the same cycle with requests=4'b0110, g=1 -> grants=4'b0100 next cycle, one advance only.
